// File: rtl/s_ram_pkg.sv
// Shared definitions for the S-RAM shuffle (RC4 key scheduling) block.
package s_ram_pkg;

    localparam int unsigned default_data_width       = 8;
    localparam int unsigned default_s_ram_addr_width = 8;
    localparam int unsigned default_key_bytes        = 3;

    typedef enum logic [3:0] {
        IDLE,
        REQUEST,
        INIT,
        RD_I,
        WT_I,
        LD_I,
        RD_J,
        WT_J,
        LD_J,
        WR_I,
        WR_J,
        DONE
    } state_t;

endpackage

// File: rtl/s_ram_shuffle_if.sv
// Start/finish handshake, key and S-RAM arbiter/memory signals of the shuffle block.
interface s_ram_shuffle_if
    import s_ram_pkg::*;
#(
    parameter int unsigned data_width       = default_data_width,
    parameter int unsigned s_ram_addr_width = default_s_ram_addr_width,
    parameter int unsigned key_bytes        = default_key_bytes
);

    logic                              s_ram_shuffle_start;
    logic                              s_ram_shuffle_finish;
    logic [key_bytes*data_width-1:0]   secret_key;
    logic                              s_ram_access_request;
    logic                              s_ram_access_granted;
    logic [s_ram_addr_width-1:0]       s_ram_addr;
    logic [data_width-1:0]             s_ram_data;
    logic                              s_ram_wren;
    logic [data_width-1:0]             s_ram_q;

    // The shuffle engine side.
    modport master (
        input  s_ram_shuffle_start,
        input  secret_key,
        input  s_ram_access_granted,
        input  s_ram_q,
        output s_ram_shuffle_finish,
        output s_ram_access_request,
        output s_ram_addr,
        output s_ram_data,
        output s_ram_wren
    );

    // Controller, arbiter and S-RAM side.
    modport slave (
        output s_ram_shuffle_start,
        output secret_key,
        output s_ram_access_granted,
        output s_ram_q,
        input  s_ram_shuffle_finish,
        input  s_ram_access_request,
        input  s_ram_addr,
        input  s_ram_data,
        input  s_ram_wren
    );

endinterface

// File: rtl/s_ram_shuffle_key_sel.sv
// Modulo-key_bytes key index counter and key byte selector (byte 0 is the MSB).
module s_ram_key_sel
    import s_ram_pkg::*;
#(
    parameter int unsigned data_width = default_data_width,
    parameter int unsigned key_bytes  = default_key_bytes
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            clr,
    input  logic                            adv,
    input  logic [key_bytes*data_width-1:0] key,
    output logic [data_width-1:0]           key_byte
);

    localparam int unsigned kw = (key_bytes > 1) ? $clog2(key_bytes) : 1;

    logic [kw-1:0] k;

    // Key index: cleared at shuffle start, wraps at key_bytes-1 without a divider.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k <= '0;
        end else if (clr) begin
            k <= '0;
        end else if (adv) begin
            k <= (k == kw'(key_bytes - 1)) ? '0 : k + 1'b1;
        end
    end

    // Byte mux: key byte k, counting from the most significant byte.
    always_comb begin
        key_byte = '0;
        for (int unsigned b = 0; b < key_bytes; b++) begin
            if (k == kw'(b)) begin
                key_byte = key[(key_bytes-1-b)*data_width +: data_width];
            end
        end
    end

endmodule

// File: rtl/s_ram_shuffle.sv
// RC4 key-scheduling shuffle over an identity-initialised S-RAM with a
// two-cycle read latency; 8 cycles per iteration (read i, read j, write both).
module s_ram_shuffle
    import s_ram_pkg::*;
#(
    parameter int unsigned data_width       = default_data_width,
    parameter int unsigned s_ram_addr_width = default_s_ram_addr_width,
    parameter int unsigned key_bytes        = default_key_bytes
) (
    input  logic                  clk,
    input  logic                  rst_n,
    s_ram_shuffle_if.master       bus
);

    state_t state, state_next;

    logic [s_ram_addr_width-1:0] i;
    logic [data_width-1:0]       j;
    logic [data_width-1:0]       si;
    logic [data_width-1:0]       sj;
    logic [data_width-1:0]       key_byte;
    logic                        last_i;

    assign last_i = (i == '1);

    s_ram_key_sel #(
        .data_width (data_width),
        .key_bytes  (key_bytes)
    ) u_key_sel (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (state == INIT),
        .adv      ((state == WR_J) && !last_i),
        .key      (bus.secret_key),
        .key_byte (key_byte)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.s_ram_shuffle_start)   state_next = REQUEST;
            REQUEST: if (bus.s_ram_access_granted)  state_next = INIT;
            INIT:    state_next = RD_I;
            RD_I:    state_next = WT_I;
            WT_I:    state_next = LD_I;
            LD_I:    state_next = RD_J;
            RD_J:    state_next = WT_J;
            WT_J:    state_next = LD_J;
            LD_J:    state_next = WR_I;
            WR_I:    state_next = WR_J;
            WR_J:    state_next = last_i ? DONE : RD_I;
            DONE:    if (!bus.s_ram_shuffle_start)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from state; address/data idle at zero outside the access states.
    always_comb begin
        bus.s_ram_access_request = 1'b0;
        bus.s_ram_shuffle_finish = 1'b0;
        bus.s_ram_addr           = '0;
        bus.s_ram_data           = '0;
        bus.s_ram_wren           = 1'b0;
        case (state)
            REQUEST, INIT: begin
                bus.s_ram_access_request = 1'b1;
            end
            RD_I, WT_I, LD_I: begin
                bus.s_ram_access_request = 1'b1;
                bus.s_ram_addr           = i;
            end
            RD_J, WT_J, LD_J: begin
                bus.s_ram_access_request = 1'b1;
                bus.s_ram_addr           = s_ram_addr_width'(j);
            end
            WR_I: begin
                bus.s_ram_access_request = 1'b1;
                bus.s_ram_addr           = i;
                bus.s_ram_data           = sj;
                bus.s_ram_wren           = 1'b1;
            end
            WR_J: begin
                bus.s_ram_access_request = 1'b1;
                bus.s_ram_addr           = s_ram_addr_width'(j);
                bus.s_ram_data           = si;
                bus.s_ram_wren           = 1'b1;
            end
            DONE: begin
                bus.s_ram_shuffle_finish = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath: indices and the two swap operands; j accumulates modulo 2^data_width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i  <= '0;
            j  <= '0;
            si <= '0;
            sj <= '0;
        end else begin
            case (state)
                INIT: begin
                    i <= '0;
                    j <= '0;
                end
                LD_I: begin
                    si <= bus.s_ram_q;
                    j  <= j + bus.s_ram_q + key_byte;
                end
                LD_J: begin
                    sj <= bus.s_ram_q;
                end
                WR_J: begin
                    if (!last_i) i <= i + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_s_ram_shuffle.sv
// Bench for s_ram_shuffle: identity-filled S-RAM model with 2-cycle read
// latency, first-iteration vector table, and full-run sequences.
module tb_s_ram_shuffle;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 8;
    localparam int unsigned KB = 3;
    localparam int unsigned NW = 1 << AW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    s_ram_shuffle_if #(.data_width(DW), .s_ram_addr_width(AW), .key_bytes(KB)) bus ();

    s_ram_shuffle #(.data_width(DW), .s_ram_addr_width(AW), .key_bytes(KB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // S-RAM model: synchronous write, read data two edges after the address.
    logic [DW-1:0] mem [NW];
    logic [DW-1:0] q_p1;
    logic          fill = 1'b0;
    int            wr_count = 0;

    always @(posedge clk) begin
        if (fill) begin
            for (int n = 0; n < int'(NW); n++) mem[n] <= DW'(n);
        end else if (bus.s_ram_wren) begin
            mem[bus.s_ram_addr] <= bus.s_ram_data;
            wr_count <= wr_count + 1;
        end
        q_p1 <= mem[bus.s_ram_addr];
        bus.s_ram_q <= q_p1;
    end

    int compared = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.s_ram_shuffle_start  = 1'b0;
        bus.s_ram_access_granted = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic do_fill();
        fill = 1'b1;
        tick();
        fill = 1'b0;
    endtask

    // Wait (bounded) for a write strobe; captures it and advances one cycle.
    task automatic wait_write(output logic [AW-1:0] a, output logic [DW-1:0] d, output bit ok);
        ok = 1'b0;
        a = '0;
        d = '0;
        for (int c = 0; c < 40; c++) begin
            if (bus.s_ram_wren) begin
                a = bus.s_ram_addr;
                d = bus.s_ram_data;
                ok = 1'b1;
                tick();
                return;
            end
            tick();
        end
    endtask

    // Reference RC4 key schedule on an identity array.
    logic [DW-1:0] model [NW];
    task automatic ksa(input logic [KB*DW-1:0] key);
        logic [DW-1:0] jj, t, kb;
        for (int n = 0; n < int'(NW); n++) model[n] = DW'(n);
        jj = '0;
        for (int n = 0; n < int'(NW); n++) begin
            kb = key[(KB-1-(n % KB))*DW +: DW];
            jj = jj + model[n] + kb;
            t = model[n];
            model[n] = model[jj];
            model[jj] = t;
        end
    endtask

    task automatic compare_mem(input string tag);
        for (int n = 0; n < int'(NW); n++) begin
            check($sformatf("%s_s[%0d]", tag, n), 32'(mem[n]), 32'(model[n]));
        end
    endtask

    task automatic wait_finish(input string tag);
        int c;
        c = 0;
        while (!bus.s_ram_shuffle_finish && c < 3000) begin
            tick();
            c++;
        end
        check({tag, "_finish_seen"}, 32'(bus.s_ram_shuffle_finish), 32'd1);
    endtask

    typedef struct {
        logic [KB*DW-1:0] key;
        logic [AW-1:0]    wi_addr;
        logic [DW-1:0]    wi_data;
        logic [AW-1:0]    wj_addr;
        logic [DW-1:0]    wj_data;
    } vec_t;

    vec_t vecs [5];

    initial begin
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit            ok;
        int            n;
        int            wc;

        // First iteration (i=0, j=S[0]+key[0]=key[0]): WR_I at 0 with S[j], WR_J at j with 0.
        vecs[0] = '{24'h010203, 8'h00, 8'h01, 8'h01, 8'h00};
        vecs[1] = '{24'h000000, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[2] = '{24'hFF0000, 8'h00, 8'hFF, 8'hFF, 8'h00};
        vecs[3] = '{24'h800000, 8'h00, 8'h80, 8'h80, 8'h00};
        vecs[4] = '{24'h05AA55, 8'h00, 8'h05, 8'h05, 8'h00};

        bus.secret_key = '0;
        bus.s_ram_shuffle_start = 1'b0;
        bus.s_ram_access_granted = 1'b0;

        // Reset state.
        #1;
        check("rst_request", 32'(bus.s_ram_access_request), 32'd0);
        check("rst_wren",    32'(bus.s_ram_wren),           32'd0);
        check("rst_addr",    32'(bus.s_ram_addr),           32'd0);
        check("rst_data",    32'(bus.s_ram_data),           32'd0);
        check("rst_finish",  32'(bus.s_ram_shuffle_finish), 32'd0);

        // Table: first write pair for each key, then abort by reset.
        for (int v = 0; v < 5; v++) begin
            do_reset();
            do_fill();
            bus.secret_key = vecs[v].key;
            bus.s_ram_shuffle_start = 1'b1;
            bus.s_ram_access_granted = 1'b1;
            wait_write(a, d, ok);
            check($sformatf("v%0d_wri_seen", v), 32'(ok), 32'd1);
            check($sformatf("v%0d_wri_addr", v), 32'(a), 32'(vecs[v].wi_addr));
            check($sformatf("v%0d_wri_data", v), 32'(d), 32'(vecs[v].wi_data));
            check($sformatf("v%0d_wrj_now", v), 32'(bus.s_ram_wren), 32'd1);
            check($sformatf("v%0d_wrj_addr", v), 32'(bus.s_ram_addr), 32'(vecs[v].wj_addr));
            check($sformatf("v%0d_wrj_data", v), 32'(bus.s_ram_data), 32'(vecs[v].wj_data));
        end

        // Grant withheld, finish latency, start held after DONE, full result.
        do_reset();
        do_fill();
        bus.secret_key = 24'h0003FF;
        bus.s_ram_shuffle_start = 1'b1;
        tick();
        for (int c = 0; c < 10; c++) begin
            check($sformatf("nogrant_req_%0d", c), 32'(bus.s_ram_access_request), 32'd1);
            check($sformatf("nogrant_wren_%0d", c), 32'(bus.s_ram_wren), 32'd0);
            tick();
        end
        bus.s_ram_access_granted = 1'b1;
        tick();                       // grant-sampling edge counts as cycle 1
        n = 1;
        while (!bus.s_ram_shuffle_finish && n < 3000) begin
            tick();
            n++;
        end
        check("finish_latency", 32'(n), 32'd2050);
        for (int c = 0; c < 4; c++) tick();
        check("finish_held", 32'(bus.s_ram_shuffle_finish), 32'd1);
        check("done_request", 32'(bus.s_ram_access_request), 32'd0);
        bus.s_ram_shuffle_start = 1'b0;
        tick();
        check("idle_finish", 32'(bus.s_ram_shuffle_finish), 32'd0);
        ksa(24'h0003FF);
        compare_mem("full");

        // Reset at iteration 100, then a clean restart.
        do_reset();
        do_fill();
        bus.s_ram_shuffle_start = 1'b1;
        bus.s_ram_access_granted = 1'b1;
        n = 0;
        wc = 0;
        while (wc < 200 && n < 3000) begin
            if (bus.s_ram_wren) wc++;
            tick();
            n++;
        end
        check("iter100_reached", 32'(wc), 32'd200);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_request", 32'(bus.s_ram_access_request), 32'd0);
        check("abort_wren",    32'(bus.s_ram_wren),           32'd0);
        check("abort_addr",    32'(bus.s_ram_addr),           32'd0);
        check("abort_data",    32'(bus.s_ram_data),           32'd0);
        check("abort_finish",  32'(bus.s_ram_shuffle_finish), 32'd0);
        bus.s_ram_shuffle_start = 1'b0;
        wc = wr_count;
        tick();
        tick();
        tick();
        check("abort_no_writes", 32'(wr_count - wc), 32'd0);
        rst_n = 1'b1;
        do_fill();
        bus.s_ram_shuffle_start = 1'b1;
        wait_finish("restart");
        bus.s_ram_shuffle_start = 1'b0;
        tick();
        compare_mem("restart");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/s_ram_shuffle.md
S_RAM_SHUFFLE -- requirements
Module: s_ram_shuffle

Interface
REQ-001 Parameters: data_width default 8, S-RAM word width; s_ram_addr_width default 8, S-RAM address width; key_bytes default 3, secret key length in bytes.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 s_ram_shuffle_start  input  1  start request (start/finish protocol).
REQ-005 s_ram_shuffle_finish  output  1  shuffle complete (start/finish protocol).
REQ-006 secret_key  input  key_bytes*data_width  key; byte 0 = most significant byte.
REQ-007 s_ram_access_request  output  1  request S-RAM ownership from arbiter.
REQ-008 s_ram_access_granted  input  1  arbiter grant.
REQ-009 s_ram_addr  output  s_ram_addr_width  S-RAM address.
REQ-010 s_ram_data  output  data_width  S-RAM write data.
REQ-011 s_ram_wren  output  1  S-RAM write enable.
REQ-012 s_ram_q  input  data_width  S-RAM read data, valid 2 cycles after address presented.

Function
REQ-013 Block SHALL perform RC4 key scheduling on S-RAM pre-filled with S[n]=n: for i=0..2^addr_width-1: j=j+S[i]+key[i mod key_bytes]; swap S[i],S[j].
REQ-014 States SHALL be IDLE, REQUEST, INIT, RD_I, WT_I, LD_I, RD_J, WT_J, LD_J, WR_I, WR_J, DONE.
REQ-015 IDLE -> REQUEST when start=1; REQUEST -> INIT when granted=1, else hold.
REQ-016 INIT clears i, j, key index k to 0 -> RD_I.
REQ-017 RD_I: addr=i; WT_I: addr=i; LD_I: latch si=s_ram_q, j <= j+si+key byte k (mod 2^data_width).
REQ-018 RD_J: addr=j; WT_J: addr=j; LD_J: latch sj=s_ram_q.
REQ-019 WR_I: addr=i, data=sj, wren=1; WR_J: addr=j, data=si, wren=1.
REQ-020 WR_J -> DONE when i = all-ones; else i<=i+1, k<=(k=key_bytes-1)?0:k+1, -> RD_I.
REQ-021 Iteration SHALL take exactly 8 cycles; whole shuffle 256 iterations (default widths).
REQ-022 k SHALL be a modulo-key_bytes counter; no divider.
REQ-023 i=j SHALL be handled by the same sequence; second write restores si, location unchanged.
REQ-024 All additions wrap modulo 2^data_width; no carry retained.
REQ-025 s_ram_access_request SHALL be 1 in REQUEST through WR_J, 0 in IDLE and DONE.
REQ-026 wren SHALL be 1 only in WR_I/WR_J; addr/data SHALL be 0 in IDLE, REQUEST, INIT, DONE.
REQ-027 s_ram_shuffle_finish SHALL be 1 only in DONE; DONE -> IDLE when start=0, else hold.
REQ-028 start deassertion before DONE SHALL be ignored; grant sampled only in REQUEST (arbiter must not revoke).

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE; i, j, k, si, sj = 0; all outputs 0.
REQ-030 Reset mid-shuffle SHALL abort with no further writes; next start restarts from INIT.

Structure
REQ-031 Package s_ram_pkg SHALL hold state enum, default data_width, s_ram_addr_width, key_bytes.
REQ-032 One sub-module, s_ram_key_sel: mod-key_bytes counter plus byte mux giving key[k].
REQ-033 State register and datapath registers SHALL use async active-low reset flops.

Verification
REQ-034 S-RAM model S[n]=n, key 24'h010203, start, grant -> first writes addr0=8'h01, addr1=8'h00.
REQ-035 key 24'h000000 -> iteration i=0 j=0: WR_I and WR_J both addr0 data 8'h00 (i=j case).
REQ-036 Grant withheld 10 cycles -> request held, no wren; finish rises 2050 cycles after grant-sampling edge.
REQ-037 Full run vs. software RC4 KSA for key 24'h0003FF -> all 256 S-RAM words match.
REQ-038 rst_n pulsed at iteration 100 -> outputs 0 same cycle, no wren; restart -> correct final S.
REQ-039 start held high after DONE -> finish held; start low -> IDLE next cycle, finish 0.
